// File: rtl/projetoniosqsys_processador_nioii_cpu_mult_ctrl.sv
// Multiply sequencer for the Nios II three-partial-product 16x16 multiplier cell:
// issues one or two cell passes, sums the partials and applies signed corrections.
module projetoniosqsys_processador_nioii_cpu_mult_ctrl #(
    parameter int CELL_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_src1,
    input  logic [31:0] req_src2,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic [31:0] cell_src1,
    output logic [31:0] cell_src2,
    output logic        cell_en,
    input  logic [31:0] cell_p1,
    input  logic [31:0] cell_p2,
    input  logic [31:0] cell_p3
);

    typedef enum logic [2:0] {IDLE, ISS1, CAP1, ISS2, CAP2, DONE} state_t;

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULXSU = 2'b10;
    localparam logic [1:0] OP_MULXSS = 2'b11;

    localparam int            CW       = (CELL_LATENCY > 1) ? $clog2(CELL_LATENCY) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(CELL_LATENCY - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [31:0]   a_q, a_n;
    logic [31:0]   b_q, b_n;
    logic [1:0]    op_q, op_n;
    logic [31:0]   ll_q, ll_n;
    logic [32:0]   mid_q, mid_n;

    logic        req_ready_n;
    logic        rsp_valid_n;
    logic [31:0] rsp_result_n;
    logic        cell_en_n;
    logic [31:0] cell_src1_n;
    logic [31:0] cell_src2_n;

    logic [32:0] mid_sum;
    logic [31:0] sum_ll;
    logic [32:0] sum_mid;
    logic [31:0] sum_hh;
    logic [63:0] product;
    logic [31:0] hi;

    // NOTE: every always_comb output is given a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        a_n          = a_q;
        b_n          = b_q;
        op_n         = op_q;
        ll_n         = ll_q;
        mid_n        = mid_q;
        req_ready_n  = req_ready;
        rsp_valid_n  = rsp_valid;
        rsp_result_n = rsp_result;
        cell_en_n    = cell_en;
        cell_src1_n  = cell_src1;
        cell_src2_n  = cell_src2;

        mid_sum = {1'b0, cell_p2} + {1'b0, cell_p3};

        // One shared adder: in CAP1 it sees the fresh pass-1 partials (HH = 0, only the low word matters);
        // in CAP2 it sees the latched LL/MID plus hi·hi straight from the cell.
        if (state == CAP2) begin
            sum_ll  = ll_q;
            sum_mid = mid_q;
            sum_hh  = cell_p1;
        end else begin
            sum_ll  = cell_p1;
            sum_mid = mid_sum;
            sum_hh  = 32'h0;
        end
        product = {sum_hh, 32'h0} + {15'h0, sum_mid, 16'h0} + {32'h0, sum_ll};

        hi = product[63:32];
        if ((op_q == OP_MULXSU || op_q == OP_MULXSS) && a_q[31]) hi = hi - b_q;
        if (op_q == OP_MULXSS && b_q[31])                        hi = hi - a_q;

        case (state)
            IDLE: begin
                req_ready_n = 1'b1;
                if (req_valid && req_ready) begin
                    a_n         = req_src1;
                    b_n         = req_src2;
                    op_n        = req_op;
                    cell_src1_n = req_src1;
                    cell_src2_n = req_src2;
                    cell_en_n   = 1'b1;
                    cnt_n       = CNT_LOAD;
                    req_ready_n = 1'b0;
                    state_n     = ISS1;
                end
            end
            ISS1: begin
                if (cnt == '0) begin
                    cell_en_n = 1'b0;
                    state_n   = CAP1;
                end else begin
                    cnt_n = cnt - CNT_ONE;
                end
            end
            CAP1: begin
                ll_n  = cell_p1;
                mid_n = mid_sum;
                if (op_q == OP_MUL) begin
                    rsp_result_n = product[31:0];
                    rsp_valid_n  = 1'b1;
                    state_n      = DONE;
                end else begin
                    cell_src1_n = {16'h0, a_q[31:16]};
                    cell_src2_n = {16'h0, b_q[31:16]};
                    cell_en_n   = 1'b1;
                    cnt_n       = CNT_LOAD;
                    state_n     = ISS2;
                end
            end
            ISS2: begin
                if (cnt == '0) begin
                    cell_en_n = 1'b0;
                    state_n   = CAP2;
                end else begin
                    cnt_n = cnt - CNT_ONE;
                end
            end
            CAP2: begin
                rsp_result_n = hi;
                rsp_valid_n  = 1'b1;
                state_n      = DONE;
            end
            DONE: begin
                if (rsp_ready) begin
                    rsp_valid_n = 1'b0;
                    req_ready_n = 1'b1;
                    state_n     = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            ll_q       <= '0;
            mid_q      <= '0;
            req_ready  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            cell_en    <= 1'b0;
            cell_src1  <= '0;
            cell_src2  <= '0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            a_q        <= a_n;
            b_q        <= b_n;
            op_q       <= op_n;
            ll_q       <= ll_n;
            mid_q      <= mid_n;
            req_ready  <= req_ready_n;
            rsp_valid  <= rsp_valid_n;
            rsp_result <= rsp_result_n;
            cell_en    <= cell_en_n;
            cell_src1  <= cell_src1_n;
            cell_src2  <= cell_src2_n;
        end
    end

endmodule

// File: tb/tb_projetoniosqsys_processador_nioii_cpu_mult_ctrl.sv
// Scoreboard bench: two sequencers (cell latency 1 and 3) each driving a behavioural multiplier cell;
// expected results come from full 64-bit products of sign/zero-extended operands.
module tb_projetoniosqsys_processador_nioii_cpu_mult_ctrl;

    typedef struct {
        int          inst;
        logic [31:0] val;
        int          acc;
        int          lat;
    } exp_t;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          hold;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic [1:0]  req_op     [2];
    logic [31:0] req_src1   [2];
    logic [31:0] req_src2   [2];
    logic        rsp_valid  [2];
    logic        rsp_ready  [2];
    logic [31:0] rsp_result [2];
    logic [31:0] cell_src1  [2];
    logic [31:0] cell_src2  [2];
    logic        cell_en    [2];
    logic [31:0] cell_p1    [2];
    logic [31:0] cell_p2    [2];
    logic [31:0] cell_p3    [2];

    logic [31:0] last_src1 [2];
    logic [31:0] last_src2 [2];

    exp_t exp_q[$];
    int   cycle;
    int   n_checks;
    int   n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int lat_of(input int g);
        return (g == 0) ? 1 : 3;
    endfunction

    // Reference: the architectural product of the extended operands, low or high word.
    function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb, p;
        ea = (op[1] && a[31]) ? {32'hFFFF_FFFF, a} : {32'h0, a};
        eb = (op == 2'b11 && b[31]) ? {32'hFFFF_FFFF, b} : {32'h0, b};
        p  = ea * eb;
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    for (genvar g = 0; g < 2; g++) begin : gen_u
        localparam int LAT = (g == 0) ? 1 : 3;

        logic [31:0] pp1 [LAT];
        logic [31:0] pp2 [LAT];
        logic [31:0] pp3 [LAT];
        int          run;
        bit          stable;
        bit          seen;
        logic [31:0] r1, r2;
        exp_t        e;

        projetoniosqsys_processador_nioii_cpu_mult_ctrl #(.CELL_LATENCY(LAT)) dut (
            .clk        (clk),
            .reset      (reset),
            .req_valid  (req_valid[g]),
            .req_ready  (req_ready[g]),
            .req_op     (req_op[g]),
            .req_src1   (req_src1[g]),
            .req_src2   (req_src2[g]),
            .rsp_valid  (rsp_valid[g]),
            .rsp_ready  (rsp_ready[g]),
            .rsp_result (rsp_result[g]),
            .cell_src1  (cell_src1[g]),
            .cell_src2  (cell_src2[g]),
            .cell_en    (cell_en[g]),
            .cell_p1    (cell_p1[g]),
            .cell_p2    (cell_p2[g]),
            .cell_p3    (cell_p3[g])
        );

        // Behavioural cell: enable-gated input register followed by LAT-1 free-running stages.
        always @(posedge clk) begin
            if (cell_en[g]) begin
                pp1[0] <= 32'(cell_src1[g][15:0])  * 32'(cell_src2[g][15:0]);
                pp2[0] <= 32'(cell_src1[g][15:0])  * 32'(cell_src2[g][31:16]);
                pp3[0] <= 32'(cell_src1[g][31:16]) * 32'(cell_src2[g][15:0]);
            end
            for (int i = 1; i < LAT; i++) begin
                pp1[i] <= pp1[i-1];
                pp2[i] <= pp2[i-1];
                pp3[i] <= pp3[i-1];
            end
        end
        assign cell_p1[g] = pp1[LAT-1];
        assign cell_p2[g] = pp2[LAT-1];
        assign cell_p3[g] = pp3[LAT-1];

        // Monitor: cell_en pulse length / operand stability, and response scoreboard.
        always @(negedge clk) begin
            if (reset) begin
                run  = 0;
                seen = 1'b0;
            end else begin
                if (cell_en[g]) begin
                    if (run == 0) begin
                        r1     = cell_src1[g];
                        r2     = cell_src2[g];
                        stable = 1'b1;
                    end else if (cell_src1[g] !== r1 || cell_src2[g] !== r2) begin
                        stable = 1'b0;
                    end
                    run++;
                end else if (run != 0) begin
                    check($sformatf("u%0d_cell_en_len", g), run, LAT);
                    check($sformatf("u%0d_cell_src_stable", g), stable, 1);
                    last_src1[g] = r1;
                    last_src2[g] = r2;
                    run = 0;
                end
                if (rsp_valid[g] && !seen) begin
                    seen = 1'b1;
                    if (exp_q.size() == 0) begin
                        check($sformatf("u%0d_rsp_spurious", g), rsp_valid[g], 0);
                    end else begin
                        e = exp_q.pop_front();
                        check($sformatf("u%0d_rsp_result", g), rsp_result[g], e.val);
                        check($sformatf("u%0d_rsp_latency", g), cycle - e.acc, e.lat);
                    end
                end else if (!rsp_valid[g]) begin
                    seen = 1'b0;
                end
            end
        end
    end

    // Called at a negedge; the request is accepted on the first rising edge with req_ready high.
    task automatic issue(input int g, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit push, output int waits);
        exp_t e;
        req_op[g]    = op;
        req_src1[g]  = a;
        req_src2[g]  = b;
        req_valid[g] = 1'b1;
        waits = 0;
        while (!req_ready[g] && waits < 100) begin
            @(negedge clk);
            waits++;
        end
        if (!req_ready[g]) begin
            check("req_ready_timeout", req_ready[g], 1);
            req_valid[g] = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        req_valid[g] = 1'b0;
        req_src1[g]  = $urandom;
        req_src2[g]  = $urandom;
        req_op[g]    = 2'($urandom);
        if (push) begin
            e.inst = g;
            e.val  = ref_mul(op, a, b);
            e.acc  = cycle;
            e.lat  = (op == 2'b00) ? lat_of(g) + 1 : 2 * lat_of(g) + 2;
            exp_q.push_back(e);
        end
    endtask

    // Waits for the response, holds it off for 'hold' cycles, then completes the handshake.
    task automatic wait_rsp(input int g, input int hold);
        int          n;
        logic [31:0] r;
        n = 0;
        @(negedge clk);
        while (!rsp_valid[g] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!rsp_valid[g]) begin
            check("rsp_timeout", rsp_valid[g], 1);
            return;
        end
        r = rsp_result[g];
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("bp_rsp_valid", rsp_valid[g], 1);
            check("bp_rsp_result", rsp_result[g], r);
            check("bp_req_ready", req_ready[g], 0);
        end
        rsp_ready[g] = 1'b1;
        @(negedge clk);
        rsp_ready[g] = 1'b0;
        check("post_hs_rsp_valid", rsp_valid[g], 0);
        check("post_hs_req_ready", req_ready[g], 1);
    endtask

    function automatic logic [31:0] rand_operand();
        logic [31:0] corner [4];
        corner[0] = 32'h0000_0000;
        corner[1] = 32'hFFFF_FFFF;
        corner[2] = 32'h8000_0000;
        corner[3] = 32'h7FFF_FFFF;
        return ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
    endfunction

    vec_t dir [6];

    initial begin
        int waits;

        dir[0] = '{2'b00, 32'h0001_0003, 32'h0002_0005, 0};
        dir[1] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0};
        dir[2] = '{2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0};
        dir[3] = '{2'b11, 32'h8000_0000, 32'h8000_0000, 5};
        dir[4] = '{2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0};
        dir[5] = '{2'b10, 32'h7FFF_FFFF, 32'h8000_0000, 1};

        cycle    = 0;
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        for (int g = 0; g < 2; g++) begin
            req_valid[g] = 1'b0;
            rsp_ready[g] = 1'b0;
            req_op[g]    = 2'b00;
            req_src1[g]  = '0;
            req_src2[g]  = '0;
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            check("rst_req_ready", req_ready[g], 0);
            check("rst_rsp_valid", rsp_valid[g], 0);
            check("rst_rsp_result", rsp_result[g], 0);
            check("rst_cell_en", cell_en[g], 0);
            check("rst_cell_src1", cell_src1[g], 0);
            check("rst_cell_src2", cell_src2[g], 0);
        end
        reset = 1'b0;
        @(negedge clk);
        check("idle_req_ready_u0", req_ready[0], 1);
        check("idle_req_ready_u1", req_ready[1], 1);

        // Directed vectors on the latency-1 unit; each request follows the previous handshake directly.
        for (int i = 0; i < 6; i++) begin
            issue(0, dir[i].op, dir[i].a, dir[i].b, 1'b1, waits);
            check("accept_immediate", waits, 0);
            wait_rsp(0, dir[i].hold);
            if (dir[i].op == 2'b01) begin
                check("pass2_src1", last_src1[0], 32'h0000_FFFF);
                check("pass2_src2", last_src2[0], 32'h0000_FFFF);
            end
        end

        // Randomized traffic on the latency-1 unit.
        for (int i = 0; i < 24; i++) begin
            issue(0, 2'($urandom), rand_operand(), rand_operand(), 1'b1, waits);
            wait_rsp(0, $urandom_range(0, 2));
        end

        // Reset while a MULXSS sits in CAP1: abandoned, then a MUL runs with normal latency.
        issue(0, 2'b11, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, waits);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_rsp_valid", rsp_valid[0], 0);
        check("abort_rsp_result", rsp_result[0], 0);
        check("abort_cell_en", cell_en[0], 0);
        check("abort_cell_src1", cell_src1[0], 0);
        check("abort_cell_src2", cell_src2[0], 0);
        check("abort_req_ready", req_ready[0], 0);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        issue(0, 2'b00, 32'd3, 32'd4, 1'b1, waits);
        wait_rsp(0, 0);

        // Latency-3 unit: directed MUL then random mix.
        issue(1, 2'b00, 32'h0001_0003, 32'h0002_0005, 1'b1, waits);
        wait_rsp(1, 0);
        for (int i = 0; i < 10; i++) begin
            issue(1, 2'($urandom), rand_operand(), rand_operand(), 1'b1, waits);
            wait_rsp(1, $urandom_range(0, 3));
        end

        repeat (5) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/projetoniosqsys_processador_nioii_cpu_mult_ctrl.md
# projetoNiosQsys_processador_nioII_cpu_mult_ctrl

Multi-cycle multiply sequencer that drives the three-partial-product 16x16 multiplier cell of the Nios II CPU and assembles its outputs into architectural results. It accepts one operation at a time over a valid/ready request channel and issues one or two passes to the cell. Pass 1 yields lo·lo, lo·hi and hi·lo. Pass 2 yields hi·hi and is used only for high-word operations. The block sums the partial products, applies the signed corrections and returns a 32-bit result over a valid/ready response channel.

## Interface
- CELL_LATENCY, 1: cycles from the first cycle `cell_en` is high with operands presented to the cycle `cell_p1..p3` are valid. Legal range is 1..4.

- clk  in  1  clock; all state changes on its rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_op  in  2  operation select: 00 MUL (low 32 bits), 01 MULXUU, 10 MULXSU (src1 signed, src2 unsigned), 11 MULXSS (both signed)
- req_src1  in  32  operand A
- req_src2  in  32  operand B
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer takes result
- rsp_result  out  32  result word
- cell_src1  out  32  operand A to the multiplier cell
- cell_src2  out  32  operand B to the multiplier cell
- cell_en  out  1  multiplier cell register enable
- cell_p1  in  32  cell partial product src1[15:0]·src2[15:0]
- cell_p2  in  32  cell partial product src1[15:0]·src2[31:16]
- cell_p3  in  32  cell partial product src1[31:16]·src2[15:0]

## Operation
- States: IDLE, ISS1, CAP1, ISS2, CAP2, DONE. All outputs are registered.
- **IDLE**
  - req_ready=1.
  - On req_valid&req_ready: latch A, B and op, then go to ISS1.
- **ISS1**
  - cell_src1=A, cell_src2=B, cell_en=1.
  - Stay for CELL_LATENCY cycles (down-counter), holding operands and cell_en, then go to CAP1.
- **CAP1**
  - cell_en=0.
  - Latch LL=cell_p1 and MID=cell_p2+cell_p3 (33-bit, carry kept).
  - op=00: result = (LL + (MID<<16)) mod 2^32, go to DONE.
  - Otherwise go to ISS2.
- **ISS2**
  - cell_src1={16'h0,A[31:16]}, cell_src2={16'h0,B[31:16]}, cell_en=1.
  - Held for CELL_LATENCY cycles, then go to CAP2.
- **CAP2**
  - HH=cell_p1.
  - P = (HH<<32) + (MID<<16) + LL, computed in 64 bits.
  - hi = P[63:32].
  - If op∈{10,11} and A[31]: hi -= B.
  - If op=11 and B[31]: hi -= A.
  - All arithmetic is mod 2^32. Go to DONE.
- **DONE**
  - rsp_valid=1, rsp_result=result.
  - On rsp_ready: next cycle IDLE, rsp_valid=0.
  - rsp_result holds its value until the next result is written.
- cell_en=0 in every state except ISS1/ISS2. In all other states cell_src1/2 hold their last value, so the cell outputs stay stable.
- No overlap: req_ready=0 in every state except IDLE.

## Timing
- Reset values, held while reset is high and on the following cycle:
  - State: IDLE.
  - Outputs: req_ready=0 while reset is high, then 1. rsp_valid=0, rsp_result=0, cell_en=0, cell_src1=0, cell_src2=0.
  - Internal registers: LL, MID and HH clear.
- Latency, request accepted at edge T, CELL_LATENCY=L:
  - MUL: rsp_valid first high in cycle T+2+L.
  - High ops: rsp_valid first high in cycle T+3+2L.
  - With L=1: MUL at T+3, high ops at T+5.
- Back-to-back requests: the next request is accepted at the earliest in the cycle after the rsp handshake.
- rsp_ready held low: rsp_valid and rsp_result stay stable indefinitely and req_ready stays 0.
- req_valid dropped before acceptance: no effect. req_src1/2 and req_op are sampled only at the accept edge.
- Reset during any state: the operation is abandoned. No rsp_valid pulse is produced. cell_en drops the cycle after reset is seen.
- rsp_ready high outside DONE: ignored.

## Test plan
- MUL, A=0x00010003, B=0x00020005 -> rsp_result=0x000B000F at T+3 (L=1). cell_en is high for exactly 1 cycle.
- MULXUU, A=B=0xFFFFFFFF -> rsp_result=0xFFFFFFFE at T+5. Second pass drives cell_src1=cell_src2=0x0000FFFF.
- MULXSS checks:
  - A=B=0xFFFFFFFF -> 0x00000000.
  - A=B=0x80000000 -> 0x40000000.
- MULXSU, A=0xFFFFFFFF, B=0xFFFFFFFF -> 0xFFFFFFFF.
- MULXSU, A=0x7FFFFFFF, B=0x80000000 -> 0x3FFFFFFF.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> result, rsp_valid and req_ready=0 all stable. Handshake -> IDLE next cycle, and a new request is accepted there.
- Reset asserted in CAP1 of a MULXSS:
  - No response. All outputs at reset values.
  - A following MUL 3×4 returns 0x0000000C with normal latency.
- CELL_LATENCY=3: MUL 0x00010003×0x00020005 -> rsp_valid at T+5. cell_en is held 3 cycles with operands constant.
